// File: rtl/wbarb_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the zero-register address and the starvation-guard state encoding.
package wbarb_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_ADDR_W = 5;

    // Writes to this address are architecturally discarded.
    localparam logic [4:0] XZR_ADDR = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } wbarb_state_e;

endpackage

// File: rtl/wbarb_fifo.sv
// Small circular queue of pending LLU results {rd, data}.
// QDEPTH must be a power of two so the pointers wrap naturally.
module wbarb_fifo #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_rd,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [ADDR_W-1:0]              head_rd,
    output logic [DATA_W-1:0]              head_data,
    output logic [$clog2(QDEPTH+1)-1:0]    count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH+1);

    logic [ADDR_W-1:0] rd_mem_r   [QDEPTH];
    logic [DATA_W-1:0] data_mem_r [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_s;
    logic              pop_s;

    assign full      = (count_r == CNT_W'(QDEPTH));
    assign empty     = (count_r == '0);
    assign push_s    = push && !full;
    assign pop_s     = pop && !empty;
    assign head_rd   = rd_mem_r[rd_ptr_r];
    assign head_data = data_mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                rd_mem_r[i]   <= '0;
                data_mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                rd_mem_r[wr_ptr_r]   <= push_rd;
                data_mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the writeback stage (priority)
// and queued long-latency-unit results. WBARB_STARVE_GUARD_EN adds a one-cycle
// pipeline stall when a queued result has been denied for MAX_WAIT cycles.
module regfile_write_arbiter
    import wbarb_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int QDEPTH   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wb_regwrite,
    input  logic [ADDR_W-1:0]              wb_rd,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           llu_valid,
    input  logic [ADDR_W-1:0]              llu_rd,
    input  logic [DATA_W-1:0]              llu_data,
    output logic                           llu_ready,
    output logic                           stall_pipe,
    output logic                           rf_we,
    output logic [ADDR_W-1:0]              rf_rd,
    output logic [DATA_W-1:0]              rf_wdata,
    output logic [$clog2(QDEPTH+1)-1:0]    q_count
);

    localparam int CNT_W = $clog2(QDEPTH+1);

    if (MAX_WAIT < 1 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_param_check
        $error("regfile_write_arbiter: QDEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
    end

    logic [ADDR_W-1:0] xzr_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [ADDR_W-1:0] head_rd_s;
    logic [DATA_W-1:0] head_data_s;
    logic              push_s;
    logic              pop_s;
    logic              pipe_grant_s;
    logic              stall_pipe_s;
    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_rd_r;
    logic [DATA_W-1:0] rf_wdata_r;

    assign xzr_s        = ADDR_W'(XZR_ADDR);
    assign llu_ready    = !reset && !fifo_full_s;
    // XZR-bound LLU results complete the handshake but are never queued.
    assign push_s       = llu_valid && llu_ready && (llu_rd != xzr_s);
    assign pipe_grant_s = !stall_pipe_s && wb_regwrite && (wb_rd != xzr_s);
    assign pop_s        = !pipe_grant_s && !fifo_empty_s;

    wbarb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_rd   (llu_rd),
        .push_data (llu_data),
        .pop       (pop_s),
        .head_rd   (head_rd_s),
        .head_data (head_data_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

`ifdef WBARB_STARVE_GUARD_EN
    localparam int WCNT_W = $clog2(MAX_WAIT+1);

    wbarb_state_e      state_r;
    wbarb_state_e      state_next_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_cnt_next_s;
    logic              stall_pipe_r;
    logic              remain_s;

    // Queue still holds an entry after this cycle's push/pop.
    assign remain_s = push_s ||
                      (!fifo_empty_s && !(pop_s && fifo_count_s == CNT_W'(1)));

    // Starvation guard next-state and wait counter.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        case (state_r)
            IDLE: begin
                wait_cnt_next_s = '0;
                if (push_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (pop_s) begin
                    wait_cnt_next_s = '0;
                    state_next_s    = remain_s ? WAIT : IDLE;
                end else if (wait_cnt_r == WCNT_W'(MAX_WAIT)) begin
                    state_next_s = STALL;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WCNT_W'(1);
                end
            end
            STALL: begin
                wait_cnt_next_s = '0;
                state_next_s    = remain_s ? WAIT : IDLE;
            end
            default: begin
                wait_cnt_next_s = '0;
                state_next_s    = IDLE;
            end
        endcase
    end

    // Guard state register; stall_pipe is high exactly while in STALL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            wait_cnt_r   <= '0;
            stall_pipe_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            wait_cnt_r   <= wait_cnt_next_s;
            stall_pipe_r <= (state_next_s == STALL);
        end
    end

    assign stall_pipe_s = stall_pipe_r;
`else
    assign stall_pipe_s = 1'b0;
`endif

    // Registered write port: pipeline first, then queue head, else idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_r    <= 1'b0;
            rf_rd_r    <= '0;
            rf_wdata_r <= '0;
        end else if (pipe_grant_s) begin
            rf_we_r    <= 1'b1;
            rf_rd_r    <= wb_rd;
            rf_wdata_r <= wb_data;
        end else if (pop_s) begin
            rf_we_r    <= 1'b1;
            rf_rd_r    <= head_rd_s;
            rf_wdata_r <= head_data_s;
        end else begin
            rf_we_r    <= 1'b0;
            rf_rd_r    <= '0;
            rf_wdata_r <= '0;
        end
    end

    assign stall_pipe = stall_pipe_s;
    assign rf_we      = rf_we_r;
    assign rf_rd      = rf_rd_r;
    assign rf_wdata   = rf_wdata_r;
    assign q_count    = fifo_count_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (QDEPTH=2, MAX_WAIT=4); the
// starvation section follows WBARB_STARVE_GUARD_EN.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        llu_valid;
    logic [4:0]  llu_rd;
    logic [63:0] llu_data;
    logic        llu_ready;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic [1:0]  q_count;

    int n_tests;
    int n_fail;

    regfile_write_arbiter #(
        .DATA_W   (64),
        .ADDR_W   (5),
        .QDEPTH   (2),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .llu_valid   (llu_valid),
        .llu_rd      (llu_rd),
        .llu_data    (llu_data),
        .llu_ready   (llu_ready),
        .stall_pipe  (stall_pipe),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] rd,
                          input logic [63:0] data);
        chk({tag, ".we"}, {63'd0, rf_we}, {63'd0, we});
        chk({tag, ".rd"}, {59'd0, rf_rd}, {59'd0, rd});
        chk({tag, ".data"}, rf_wdata, data);
    endtask

    task automatic chk_q(input string tag, input logic [1:0] q);
        chk({tag, ".q_count"}, {62'd0, q_count}, {62'd0, q});
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        chk(tag, {63'd0, obs}, {63'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        wb_regwrite = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 64'd0;
        llu_valid   = 1'b0;
        llu_rd      = 5'd0;
        llu_data    = 64'd0;

        // Power-on reset
        tick();
        tick();
        chk_rf("por", 1'b0, 5'd0, 64'd0);
        chk_q("por", 2'd0);
        chk_bit("por.stall", stall_pipe, 1'b0);
        chk_bit("por.ready", llu_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk_bit("por.ready_after", llu_ready, 1'b1);
        tick();

        // Pipeline write, 1-cycle latency; XZR discarded
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'd56;
        tick();
        chk_rf("pipe_wr", 1'b1, 5'd3, 64'd56);
        wb_rd = 5'd31; wb_data = 64'd77;
        tick();
        chk_rf("pipe_xzr", 1'b0, 5'd0, 64'd0);
        wb_regwrite = 1'b0;

        // LLU write into empty queue, pipeline idle: 2-cycle latency
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 64'd98;
        tick();
        chk_q("llu_push", 2'd1);
        chk_bit("llu_push.we", rf_we, 1'b0);
        llu_valid = 1'b0;
        tick();
        chk_rf("llu_wr", 1'b1, 5'd7, 64'd98);
        chk_q("llu_wr", 2'd0);

        // LLU result to XZR: accepted, not queued
        llu_valid = 1'b1; llu_rd = 5'd31; llu_data = 64'd5;
        #1;
        chk_bit("llu_xzr.ready", llu_ready, 1'b1);
        tick();
        chk_q("llu_xzr", 2'd0);
        chk_rf("llu_xzr", 1'b0, 5'd0, 64'd0);
        llu_valid = 1'b0;

        // Same-rd conflict: pipeline wins, queued value lands afterwards
        wb_regwrite = 1'b1; wb_rd = 5'd10; wb_data = 64'd100;
        llu_valid = 1'b1; llu_rd = 5'd5; llu_data = 64'd2;
        tick();
        chk_rf("conf.first", 1'b1, 5'd10, 64'd100);
        chk_q("conf.first", 2'd1);
        llu_valid = 1'b0; wb_rd = 5'd5; wb_data = 64'd1;
        tick();
        chk_rf("conf.pipe", 1'b1, 5'd5, 64'd1);
        chk_q("conf.pipe", 2'd1);
        wb_regwrite = 1'b0;
        tick();
        chk_rf("conf.queued", 1'b1, 5'd5, 64'd2);
        chk_q("conf.queued", 2'd0);

        // Full queue: third result held until a pop
        wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 64'd11;
        llu_valid = 1'b1; llu_rd = 5'd8; llu_data = 64'd80;
        tick();
        chk_q("full.1", 2'd1);
        llu_rd = 5'd9; llu_data = 64'd90;
        tick();
        chk_q("full.2", 2'd2);
        chk_bit("full.ready", llu_ready, 1'b0);
        llu_rd = 5'd11; llu_data = 64'd110;
        tick();
        chk_q("full.held", 2'd2);
        chk_rf("full.pipe", 1'b1, 5'd1, 64'd11);
        wb_regwrite = 1'b0;
        tick();
        chk_rf("full.pop1", 1'b1, 5'd8, 64'd80);
        chk_q("full.pop1", 2'd1);
        chk_bit("full.ready_again", llu_ready, 1'b1);
        tick();
        chk_rf("full.pop2", 1'b1, 5'd9, 64'd90);
        chk_q("full.pushpop", 2'd1);
        llu_valid = 1'b0;
        tick();
        chk_rf("full.pop3", 1'b1, 5'd11, 64'd110);
        chk_q("full.empty", 2'd0);

        // Starvation under continuous pipeline writes
        wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 64'd20;
        llu_valid = 1'b1; llu_rd = 5'd12; llu_data = 64'd120;
        tick();
        llu_valid = 1'b0;
        chk_q("starve.push", 2'd1);
`ifdef WBARB_STARVE_GUARD_EN
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_bit("starve.nostall", stall_pipe, 1'b0);
            chk_q("starve.wait", 2'd1);
        end
        tick();
        chk_bit("starve.stall", stall_pipe, 1'b1);
        chk_rf("starve.stall_cycle", 1'b1, 5'd2, 64'd20);
        tick();
        chk_bit("starve.release", stall_pipe, 1'b0);
        chk_rf("starve.head", 1'b1, 5'd12, 64'd120);
        chk_q("starve.drained", 2'd0);
        wb_regwrite = 1'b0;
        tick();
`else
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_bit("starve.nostall", stall_pipe, 1'b0);
            chk_q("starve.held", 2'd1);
            chk_rf("starve.pipe", 1'b1, 5'd2, 64'd20);
        end
        wb_regwrite = 1'b0;
        tick();
        chk_rf("starve.drain", 1'b1, 5'd12, 64'd120);
        chk_q("starve.drained", 2'd0);
`endif

        // Reset for 2 cycles with the queue full
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 64'd40;
        llu_valid = 1'b1; llu_rd = 5'd13; llu_data = 64'd130;
        tick();
        llu_rd = 5'd14; llu_data = 64'd140;
        tick();
        chk_q("mid.full", 2'd2);
        reset = 1'b1;
        #1;
        chk_bit("mid.ready_in_reset", llu_ready, 1'b0);
        tick();
        chk_rf("mid.rst1", 1'b0, 5'd0, 64'd0);
        chk_q("mid.rst1", 2'd0);
        chk_bit("mid.rst1.stall", stall_pipe, 1'b0);
        tick();
        chk_rf("mid.rst2", 1'b0, 5'd0, 64'd0);
        chk_bit("mid.rst2.ready", llu_ready, 1'b0);
        reset = 1'b0; wb_regwrite = 1'b0; llu_valid = 1'b0;
        #1;
        chk_bit("mid.ready_after", llu_ready, 1'b1);
        tick();
        chk_rf("mid.flushed", 1'b0, 5'd0, 64'd0);
        chk_q("mid.flushed", 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
